// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC receive path.
// CIC_COMB_ROUND_EN (optional define) adds a rounding stage and one clock of comb latency.
package cic_pkg;

  localparam int CIC_MAX_DIFF_DELAY = 2;

  // Bits needed to hold 0..value-1; never less than 1.
  function automatic int cic_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Clocks from the capturing in_strobe edge to out_strobe.
  function automatic int CIC_COMB_LATENCY(input int stages);
`ifdef CIC_COMB_ROUND_EN
    return stages + 2;
`else
    return stages + 1;
`endif
  endfunction

endpackage

// File: rtl/cic_comb.sv
// Single registered CIC comb section: y = x - x delayed by DIFF_DELAY valid samples.
module cic_comb
  import cic_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DIFF_DELAY = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  localparam int DLY = (DIFF_DELAY > CIC_MAX_DIFF_DELAY) ? CIC_MAX_DIFF_DELAY :
                       ((DIFF_DELAY < 1) ? 1 : DIFF_DELAY);

  logic [WIDTH-1:0] dly_q [DLY];
  logic [WIDTH-1:0] y_q;
  logic             v_q;

  // Delay line advances only on valid samples; subtraction wraps modulo 2^WIDTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
      y_q <= '0;
      v_q <= 1'b0;
    end else begin
      v_q <= in_valid;
      if (in_valid) begin
        y_q      <= in_data - dly_q[DLY-1];
        dly_q[0] <= in_data;
        for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign out_valid = v_q;
  assign out_data  = y_q;

endmodule

// File: rtl/cic_comb_decimator.sv
// CIC decimator rate-change plus pipelined comb chain with MSB pruning.
// CIC_COMB_ROUND_EN selects round-half-up before pruning (one extra clock of latency).
module cic_comb_decimator
  import cic_pkg::*;
#(
  parameter int IN_WIDTH   = 64,
  parameter int OUT_WIDTH  = 24,
  parameter int RATE       = 40,
  parameter int STAGES     = 5,
  parameter int DIFF_DELAY = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_strobe,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_strobe,
  output logic [OUT_WIDTH-1:0] out_data
);

  localparam int CNT_W = cic_clog2(RATE);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cnt_last;
  logic                cap_v_q;
  logic [IN_WIDTH-1:0] cap_q;

  assign cnt_last = (cnt_q == CNT_W'(RATE - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (in_strobe) cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      cap_v_q <= 1'b0;
      cap_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      cap_v_q <= in_strobe && cnt_last;
      if (in_strobe && cnt_last) cap_q <= in_data;
    end
  end

  // Index 0 is the decimated capture; index k+1 is the output of comb k.
  logic [IN_WIDTH-1:0] c_data [STAGES+1];
  logic [STAGES:0]     c_valid;

  assign c_data[0]  = cap_q;
  assign c_valid[0] = cap_v_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_comb
    cic_comb #(
      .WIDTH      (IN_WIDTH),
      .DIFF_DELAY (DIFF_DELAY)
    ) u_comb (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (c_valid[k]),
      .in_data   (c_data[k]),
      .out_valid (c_valid[k+1]),
      .out_data  (c_data[k+1])
    );
  end

  logic [IN_WIDTH-1:0] fin_data;
  logic                fin_v;

`ifdef CIC_COMB_ROUND_EN
  localparam int RSH = (IN_WIDTH > OUT_WIDTH) ? (IN_WIDTH - OUT_WIDTH - 1) : 0;
  localparam logic [IN_WIDTH-1:0] ROUND_K =
    (IN_WIDTH > OUT_WIDTH) ? (IN_WIDTH'(1) << RSH) : '0;

  logic [IN_WIDTH-1:0] rnd_q;
  logic                rnd_v_q;

  // Half-LSB offset wraps modulo 2^IN_WIDTH rather than saturating.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rnd_q   <= '0;
      rnd_v_q <= 1'b0;
    end else begin
      rnd_v_q <= c_valid[STAGES];
      if (c_valid[STAGES]) rnd_q <= c_data[STAGES] + ROUND_K;
    end
  end

  assign fin_data = rnd_q;
  assign fin_v    = rnd_v_q;
`else
  assign fin_data = c_data[STAGES];
  assign fin_v    = c_valid[STAGES];
`endif

  logic [OUT_WIDTH-1:0] out_q;
  logic                 ostb_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= '0;
      ostb_q <= 1'b0;
    end else begin
      ostb_q <= fin_v;
      if (fin_v) out_q <= fin_data[IN_WIDTH-1 -: OUT_WIDTH];
    end
  end

  assign out_strobe = ostb_q;
  assign out_data   = out_q;

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Directed bench for cic_comb_decimator: four configurations driven in lockstep.
module tb_cic_comb_decimator;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_strobe;
  logic [15:0] d_main, d_prune;
  logic        sa, sb, sc, sd;
  logic [15:0] oa, ob, od;
  logic [7:0]  oc;

  always #5 clock = ~clock;

  // A: STAGES=1 M=1, B: STAGES=3, C: 16->8 pruning, D: M=2
  cic_comb_decimator #(.IN_WIDTH(16), .OUT_WIDTH(16), .RATE(4), .STAGES(1), .DIFF_DELAY(1)) u_a (
    .clock(clock), .reset_n(reset_n), .in_strobe(in_strobe), .in_data(d_main),
    .out_strobe(sa), .out_data(oa));
  cic_comb_decimator #(.IN_WIDTH(16), .OUT_WIDTH(16), .RATE(4), .STAGES(3), .DIFF_DELAY(1)) u_b (
    .clock(clock), .reset_n(reset_n), .in_strobe(in_strobe), .in_data(d_main),
    .out_strobe(sb), .out_data(ob));
  cic_comb_decimator #(.IN_WIDTH(16), .OUT_WIDTH(8), .RATE(4), .STAGES(1), .DIFF_DELAY(1)) u_c (
    .clock(clock), .reset_n(reset_n), .in_strobe(in_strobe), .in_data(d_prune),
    .out_strobe(sc), .out_data(oc));
  cic_comb_decimator #(.IN_WIDTH(16), .OUT_WIDTH(16), .RATE(4), .STAGES(1), .DIFF_DELAY(2)) u_d (
    .clock(clock), .reset_n(reset_n), .in_strobe(in_strobe), .in_data(d_main),
    .out_strobe(sd), .out_data(od));

`ifdef CIC_COMB_ROUND_EN
  localparam int          LAT1 = 3;
  localparam int          LAT3 = 5;
  localparam logic [15:0] C_SS = 16'h0002;
`else
  localparam int          LAT1 = 2;
  localparam int          LAT3 = 4;
  localparam logic [15:0] C_SS = 16'h0001;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int ecnt = 0;

  logic [15:0] exp_q[$];
  logic [15:0] qa[$], qb[$], qc[$], qd[$];
  int          ea[$], eb[$], ec[$], cap_q[$];

  always @(posedge clock) ecnt <= ecnt + 1;

  always @(negedge clock) begin
    if (sa) begin qa.push_back(oa); ea.push_back(ecnt); end
    if (sb) begin qb.push_back(ob); eb.push_back(ecnt); end
    if (sc) begin qc.push_back({8'h00, oc}); ec.push_back(ecnt); end
    if (sd) qd.push_back(od);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Compares a captured output queue against exp_q, draining exp_q.
  task automatic cmp_q(input string tag, input logic [15:0] act_q[$]);
    check({tag, "_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && exp_q.size() > 0; i++) begin
      check($sformatf("%s[%0d]", tag, i), act_q[i], exp_q.pop_front());
    end
    exp_q.delete();
  endtask

  task automatic check_lat(input string tag, input int e[$], input int lat, input int spacing);
    for (int i = 0; i < e.size() && i < cap_q.size(); i++) begin
      check($sformatf("%s_lat[%0d]", tag, i), e[i] - cap_q[i], lat);
      if (i > 0) check($sformatf("%s_gap[%0d]", tag, i), e[i] - e[i-1], spacing);
    end
  endtask

  task automatic clear_mon();
    qa.delete(); qb.delete(); qc.delete(); qd.delete();
    ea.delete(); eb.delete(); ec.delete(); cap_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    clear_mon();
  endtask

  // Ramp: d_main = start+i, d_prune = i*0x60; gap idle clocks between strobes.
  task automatic run_ramp(input logic [15:0] start, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      in_strobe = 1'b1;
      d_main    = start + 16'(i);
      d_prune   = 16'(i * 'h60);
      @(posedge clock);
      #1;
      if (i % 4 == 3) cap_q.push_back(ecnt);
      in_strobe = 1'b0;
      repeat (gap) begin @(posedge clock); #1; end
    end
    repeat (8) @(posedge clock);
    #1;
  endtask

  task automatic check_ramp0(input string tag, input int spacing);
    exp_q = '{16'h0003, 16'h0004, 16'h0004, 16'h0004, 16'h0004, 16'h0004};
    cmp_q({tag, "_a"}, qa);
    exp_q = '{16'h0003, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    cmp_q({tag, "_b"}, qb);
    exp_q = '{16'h0001, C_SS, C_SS, C_SS, C_SS, C_SS};
    cmp_q({tag, "_c"}, qc);
    exp_q = '{16'h0003, 16'h0007, 16'h0008, 16'h0008, 16'h0008, 16'h0008};
    cmp_q({tag, "_d"}, qd);
    check_lat({tag, "_a"}, ea, LAT1, spacing);
    check_lat({tag, "_b"}, eb, LAT3, spacing);
    check_lat({tag, "_c"}, ec, LAT1, spacing);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_strobe = 1'b0;
    d_main    = '0;
    d_prune   = '0;
    #12;
    check("rst_sa", sa, 1'b0);
    check("rst_oa", oa, 16'h0000);
    check("rst_sb", sb, 1'b0);
    check("rst_oc", oc, 8'h00);
    do_reset();

    run_ramp(16'h0000, 24, 0);
    check_ramp0("cont", 4);

    do_reset();
    run_ramp(16'h0000, 24, 2);
    check_ramp0("gapped", 12);

    do_reset();
    run_ramp(16'h7FF0, 24, 0);
    exp_q = '{16'h7FF3, 16'h0004, 16'h0004, 16'h0004, 16'h0004, 16'h0004};
    cmp_q("wrap_a", qa);
    exp_q = '{16'h7FF3, 16'h001E, 16'h7FEF, 16'h0000, 16'h0000, 16'h0000};
    cmp_q("wrap_b", qb);
    exp_q = '{16'h7FF3, 16'h7FF7, 16'h0008, 16'h0008, 16'h0008, 16'h0008};
    cmp_q("wrap_d", qd);

    // Reset one clock after a capture: nothing in flight may emerge.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_strobe = 1'b1;
      d_main    = 16'(100 + i);
      d_prune   = 16'(i * 'h60);
      @(posedge clock);
      #1;
    end
    in_strobe = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("midrst_qa", qa.size(), 0);
    check("midrst_qb", qb.size(), 0);
    check("midrst_qc", qc.size(), 0);
    check("midrst_qd", qd.size(), 0);
    check("midrst_oa", oa, 16'h0000);
    check("midrst_sa", sa, 1'b0);
    reset_n = 1'b1;
    clear_mon();
    run_ramp(16'd200, 8, 0);
    exp_q = '{16'h00CB, 16'h0004};
    cmp_q("post_a", qa);
    exp_q = '{16'h00CB, 16'hFE6E};
    cmp_q("post_b", qb);
    exp_q = '{16'h0001, C_SS};
    cmp_q("post_c", qc);
    exp_q = '{16'h00CB, 16'h00CF};
    cmp_q("post_d", qd);
    check_lat("post_a", ea, LAT1, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
